dds_tdm_cfg_sequencer: RTL

//  Runtime configuration sequencer for the 2-channel time-multiplexed DDS on clk_200 (0.5 MHz / 6 MHz refs).

---
 rtl/dds_tdm_cfg_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dds_tdm_cfg_sequencer.sv
// Config sequencer for the 2-channel TDM DDS: shadow/active phase regs,
// one AXI-Stream config packet per commit, and DDS sample channel tagging.
module dds_tdm_cfg_sequencer #(
  parameter int NUM_CH    = 2,
  parameter int CH_W      = 1,
  parameter int PHASE_W   = 16,
  parameter int APPLY_LAT = 12,
  parameter int DEF_PINC0 = 328,
  parameter int DEF_PINC1 = 3932,
  parameter int DEF_POFF  = 0
) (
  input  logic                 clk_200,
  input  logic                 rst,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [CH_W-1:0]      upd_ch,
  input  logic [PHASE_W-1:0]   upd_pinc,
  input  logic [PHASE_W-1:0]   upd_poff,
  input  logic                 commit,
  output logic [2*PHASE_W-1:0] cfg_tdata,
  output logic                 cfg_tvalid,
  input  logic                 cfg_tready,
  output logic                 cfg_tlast,
  input  logic                 dds_tvalid,
  output logic [CH_W-1:0]      ch_sel,
  output logic                 busy,
  output logic                 cfg_applied,
  output logic                 err_ch
);
  localparam int CNT_W =
    (APPLY_LAT < 1) ? 1 : $clog2(APPLY_LAT + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOAD, S_SEND, S_WAIT
  } state_t;

  state_t             state;
  logic [PHASE_W-1:0] sh_pinc  [NUM_CH];
  logic [PHASE_W-1:0] sh_poff  [NUM_CH];
  logic [PHASE_W-1:0] act_pinc [NUM_CH];
  logic [PHASE_W-1:0] act_poff [NUM_CH];
  logic               pending;
  logic [CH_W-1:0]    idx;
  logic [CH_W-1:0]    idx_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        upd_ch_ext;
  logic               ch_ok;
  logic               upd_fire;

  assign upd_ch_ext = 32'(upd_ch);
  assign ch_ok      = upd_ch_ext < 32'(NUM_CH);
  assign upd_fire   = upd_valid && upd_ready;
  assign idx_nxt    = idx + CH_W'(1);

  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_pinc[i] <= (i == 0) ? PHASE_W'(DEF_PINC0)
                               : PHASE_W'(DEF_PINC1);
        sh_poff[i] <= PHASE_W'(DEF_POFF);
      end
      err_ch <= 1'b0;
    end else begin
      err_ch <= upd_fire && !ch_ok;
      if (upd_fire && ch_ok) begin
        sh_pinc[upd_ch] <= upd_pinc;
        sh_poff[upd_ch] <= upd_poff;
      end
    end
  end

  // Packet words come from the active snapshot, so shadow
  // writes during SEND/WAIT cannot disturb a packet in flight.
  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      pending     <= 1'b1;
      idx         <= '0;
      cnt         <= '0;
      upd_ready   <= 1'b0;
      cfg_tvalid  <= 1'b0;
      cfg_tlast   <= 1'b0;
      cfg_tdata   <= '0;
      busy        <= 1'b0;
      cfg_applied <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        act_pinc[i] <= '0;
        act_poff[i] <= '0;
      end
    end else begin
      cfg_applied <= 1'b0;
      if (commit) pending <= 1'b1;
      unique case (state)
        S_INIT: begin
          upd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_IDLE: begin
          if (pending) begin
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < NUM_CH; i++) begin
            act_pinc[i] <= sh_pinc[i];
            act_poff[i] <= sh_poff[i];
          end
          if (!commit) pending <= 1'b0;
          idx        <= '0;
          cfg_tvalid <= 1'b1;
          cfg_tdata  <= {sh_poff[0], sh_pinc[0]};
          cfg_tlast  <= (LAST_CH == '0);
          state      <= S_SEND;
        end
        S_SEND: begin
          if (cfg_tready) begin
            if (idx == LAST_CH) begin
              cfg_tvalid <= 1'b0;
              cfg_tlast  <= 1'b0;
              cnt        <= CNT_W'(APPLY_LAT);
              state      <= S_WAIT;
            end else begin
              idx       <= idx_nxt;
              cfg_tdata <= {act_poff[idx_nxt],
                            act_pinc[idx_nxt]};
              cfg_tlast <= (idx_nxt == LAST_CH);
            end
          end
        end
        S_WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            cfg_applied <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // DDS emits channels in fixed TDM order; config never re-aligns it.
  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      ch_sel <= '0;
    end else if (dds_tvalid) begin
      ch_sel <= (ch_sel == LAST_CH) ? '0 : ch_sel + CH_W'(1);
    end
  end

endmodule
